// File: rtl/cpc_memory_mapper.sv
// CPC 6128-style memory mapper: decodes the gate-array RAM/ROM configuration
// writes, maps CPU and video addresses onto a flat 2MB SRAM, and sequences
// SRAM accesses from RAS/CAS. A boot phase loads ROM images into SRAM.
module cpc_memory_mapper #(
  parameter int          EXP_BANKS     = 8,
  parameter int          ROM_SLOTS     = 16,
  parameter logic [20:0] ROM_BASE      = 21'h100000,
  parameter bit          BOOT_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        iorq_n,
  input  logic        wr_n,
  input  logic        cpu_n,
  input  logic        romen_n,
  input  logic        ramrd_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        mwe_n,
  input  logic        en244_n,
  input  logic [15:0] vram_addr,
  output logic [7:0]  data_to_cpu,
  output logic        memory_oe_n,
  output logic [7:0]  data_to_ga,
  output logic [20:0] sram_addr,
  output logic [7:0]  sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [7:0]  sram_dq_in,
  output logic        sram_we_n,
  input  logic [20:0] boot_addr,
  input  logic [7:0]  boot_data,
  input  logic        boot_req,
  output logic        boot_ack,
  input  logic        boot_done,
  output logic        rom_initialised
);

  typedef enum logic [2:0] {S_BOOT, S_IDLE, S_ROW, S_RD, S_WR} state_t;

  localparam logic [2:0] EXP_MASK = 3'(EXP_BANKS - 1);
  localparam logic [8:0] SLOTS9   = 9'(ROM_SLOTS);
  localparam logic [6:0] ROM_WIN  = ROM_BASE[20:14];

  state_t      state_q;
  logic [5:0]  ram_cfg_q;
  logic [7:0]  rom_sel_q;
  logic [15:0] slot_valid_q;
  logic [7:0]  rd_latch_q;
  logic [20:0] sram_addr_q;
  logic [7:0]  sram_dq_out_q;
  logic        sram_dq_oe_q;
  logic        sram_we_n_q;
  logic        boot_ack_q;
  logic        rom_init_q;
  logic        io_prev_q;
  logic        breq_prev_q;
  logic        is_rom_q;

  logic        io_fire;
  logic        boot_rise;
  logic        exp_sel;
  logic [1:0]  pg;
  logic [2:0]  blk;
  logic [20:0] ram_addr;
  logic        slot_ok;
  logic [3:0]  upper_slot;
  logic [20:0] mapped_addr;
  logic        rom_access;
  logic [6:0]  boot_win;
  logic [8:0]  boot_slot;
  logic        boot_hit;

  assign io_fire   = ~iorq_n & ~wr_n & ~io_prev_q;
  assign boot_rise = boot_req & ~breq_prev_q;

  // Address mapping: RAM mode table, ROM substitution and video override
  always_comb begin
    exp_sel = 1'b0;
    pg      = cpu_addr[15:14];
    case (ram_cfg_q[2:0])
      3'd1: if (cpu_addr[15:14] == 2'd3) begin exp_sel = 1'b1; pg = 2'd3; end
      3'd2: exp_sel = 1'b1;
      3'd3: begin
        if (cpu_addr[15:14] == 2'd1) pg = 2'd3;
        if (cpu_addr[15:14] == 2'd3) begin exp_sel = 1'b1; pg = 2'd3; end
      end
      3'd4, 3'd5, 3'd6, 3'd7:
        if (cpu_addr[15:14] == 2'd1) begin exp_sel = 1'b1; pg = ram_cfg_q[1:0]; end
      default: ;
    endcase
    blk      = ram_cfg_q[5:3] & EXP_MASK;
    ram_addr = exp_sel ? {({2'b00, blk} + 5'd1), pg, cpu_addr[13:0]}
                       : {5'b00000, pg, cpu_addr[13:0]};

    slot_ok    = ({1'b0, rom_sel_q} < SLOTS9) && slot_valid_q[rom_sel_q[3:0]];
    upper_slot = slot_ok ? rom_sel_q[3:0] : 4'd0;

    rom_access  = 1'b0;
    mapped_addr = ram_addr;
    if (cpu_n) begin
      mapped_addr = {5'b00000, vram_addr};
    end else if (!romen_n && cpu_addr[15:14] == 2'b00) begin
      rom_access  = 1'b1;
      mapped_addr = ROM_BASE + {7'b0000000, cpu_addr[13:0]};
    end else if (!romen_n && cpu_addr[15:14] == 2'b11) begin
      rom_access  = 1'b1;
      mapped_addr = ROM_BASE + {2'b00, ({1'b0, upper_slot} + 5'd1), cpu_addr[13:0]};
    end

    boot_win  = boot_addr[20:14] - ROM_WIN;
    boot_slot = {2'b00, boot_win} - 9'd1;
    boot_hit  = (boot_addr[20:14] >= ROM_WIN) && (boot_win != 7'd0) && (boot_slot < SLOTS9);
  end

  // Configuration registers, boot loader and SRAM access sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT_ON_RESET ? S_BOOT : S_IDLE;
      ram_cfg_q     <= '0;
      rom_sel_q     <= '0;
      slot_valid_q  <= BOOT_ON_RESET ? 16'h0000 : 16'h0001;
      rd_latch_q    <= '1;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
      boot_ack_q    <= 1'b0;
      io_prev_q     <= 1'b1;
      breq_prev_q   <= 1'b0;
      is_rom_q      <= 1'b0;
      if (BOOT_ON_RESET) rom_init_q <= 1'b0;
    end else begin
      io_prev_q  <= ~iorq_n & ~wr_n;
      boot_ack_q <= 1'b0;
      // Edge history freezes during a boot write so a request edge landing
      // in that cycle is still seen on the next one.
      if (sram_we_n_q || state_q != S_BOOT) breq_prev_q <= boot_req;

      if (io_fire && state_q != S_BOOT) begin
        if (!cpu_addr[15] && cpu_din[7:6] == 2'b11) ram_cfg_q <= cpu_din[5:0];
        if (!cpu_addr[13]) rom_sel_q <= cpu_din;
      end

      case (state_q)
        S_BOOT: begin
          if (!sram_we_n_q) begin
            sram_we_n_q  <= 1'b1;
            sram_dq_oe_q <= 1'b0;
            boot_ack_q   <= 1'b1;
          end else if (boot_rise && !rom_init_q) begin
            sram_addr_q   <= boot_addr;
            sram_dq_out_q <= boot_data;
            sram_dq_oe_q  <= 1'b1;
            sram_we_n_q   <= 1'b0;
            if (boot_hit) slot_valid_q[boot_slot[3:0]] <= 1'b1;
          end else if (boot_done) begin
            state_q    <= S_IDLE;
            rom_init_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (!ras_n) begin
            state_q     <= S_ROW;
            sram_addr_q <= mapped_addr;
            is_rom_q    <= rom_access;
          end
        end
        S_ROW: begin
          if (!cas_n) begin
            if (is_rom_q || mwe_n) begin
              state_q <= S_RD;
            end else begin
              state_q       <= S_WR;
              sram_we_n_q   <= 1'b0;
              sram_dq_oe_q  <= 1'b1;
              sram_dq_out_q <= cpu_din;
            end
          end else if (ras_n) begin
            state_q <= S_IDLE;
          end
        end
        S_RD: begin
          rd_latch_q <= sram_dq_in;
          if (ras_n) state_q <= S_IDLE;
        end
        S_WR: begin
          sram_dq_out_q <= cpu_din;
          if (ras_n) begin
            state_q      <= S_IDLE;
            sram_we_n_q  <= 1'b1;
            sram_dq_oe_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sram_addr       = sram_addr_q;
  assign sram_dq_out     = sram_dq_out_q;
  assign sram_dq_oe      = sram_dq_oe_q;
  assign sram_we_n       = sram_we_n_q;
  assign boot_ack        = boot_ack_q;
  assign rom_initialised = rom_init_q;
  assign memory_oe_n     = ramrd_n & romen_n;
  assign data_to_cpu     = memory_oe_n ? 8'hFF : rd_latch_q;
  assign data_to_ga      = en244_n ? rd_latch_q : cpu_din;

endmodule

// File: tb/tb_cpc_memory_mapper.sv
// Directed bench for cpc_memory_mapper: boot loading, mode table, ROM slot
// selection, IO edge decode, write strobes and reset abort.
module tb_cpc_memory_mapper;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        iorq_n, wr_n, cpu_n, romen_n, ramrd_n, ras_n, cas_n, mwe_n, en244_n;
  logic [15:0] vram_addr;
  logic [7:0]  sram_dq_in;
  logic [20:0] boot_addr;
  logic [7:0]  boot_data;
  logic        boot_req, boot_done;

  logic [7:0]  data_to_cpu, data_to_ga, sram_dq_out;
  logic        memory_oe_n, sram_dq_oe, sram_we_n, boot_ack, rom_initialised;
  logic [20:0] sram_addr;

  logic [7:0]  data_to_cpu2, data_to_ga2, sram_dq_out2;
  logic        memory_oe_n2, sram_dq_oe2, sram_we_n2, boot_ack2, rom_initialised2;
  logic [20:0] sram_addr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpc_memory_mapper dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .iorq_n(iorq_n), .wr_n(wr_n), .cpu_n(cpu_n), .romen_n(romen_n),
    .ramrd_n(ramrd_n), .ras_n(ras_n), .cas_n(cas_n), .mwe_n(mwe_n),
    .en244_n(en244_n), .vram_addr(vram_addr), .data_to_cpu(data_to_cpu),
    .memory_oe_n(memory_oe_n), .data_to_ga(data_to_ga), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n), .boot_addr(boot_addr), .boot_data(boot_data),
    .boot_req(boot_req), .boot_ack(boot_ack), .boot_done(boot_done),
    .rom_initialised(rom_initialised)
  );

  cpc_memory_mapper #(.EXP_BANKS(2)) dut2 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .iorq_n(iorq_n), .wr_n(wr_n), .cpu_n(cpu_n), .romen_n(romen_n),
    .ramrd_n(ramrd_n), .ras_n(ras_n), .cas_n(cas_n), .mwe_n(mwe_n),
    .en244_n(en244_n), .vram_addr(vram_addr), .data_to_cpu(data_to_cpu2),
    .memory_oe_n(memory_oe_n2), .data_to_ga(data_to_ga2), .sram_addr(sram_addr2),
    .sram_dq_out(sram_dq_out2), .sram_dq_oe(sram_dq_oe2), .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n2), .boot_addr(boot_addr), .boot_data(boot_data),
    .boot_req(boot_req), .boot_ack(boot_ack2), .boot_done(boot_done),
    .rom_initialised(rom_initialised2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_din = d; iorq_n = 1'b0; wr_n = 1'b0;
    tick();
    iorq_n = 1'b1; wr_n = 1'b1;
    tick();
  endtask

  // One RAS/CAS cycle; returns the latched addresses of both instances.
  task automatic access(input logic [15:0] a, input logic wr, input logic rom_n,
                        input logic [7:0] dq, output logic [20:0] a1,
                        output logic [20:0] a2, output int we_lows);
    cpu_addr = a; cpu_n = 1'b0; romen_n = rom_n; ras_n = 1'b0;
    tick();
    a1 = sram_addr; a2 = sram_addr2;
    cas_n = 1'b0; mwe_n = ~wr; sram_dq_in = dq;
    tick();
    we_lows = 0;
    if (!sram_we_n) we_lows++;
    tick();
    if (!sram_we_n) we_lows++;
    ras_n = 1'b1; cas_n = 1'b1; mwe_n = 1'b1;
    tick();
    if (!sram_we_n) we_lows++;
    romen_n = 1'b1;
  endtask

  task automatic boot_byte(input logic [20:0] a, input logic [7:0] d,
                           output int wl, output int acks, output logic [20:0] aw,
                           output logic [7:0] dw);
    boot_addr = a; boot_data = d; boot_req = 1'b1;
    wl = 0; acks = 0; aw = '0; dw = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!sram_we_n) begin wl++; aw = sram_addr; dw = sram_dq_out; end
      if (boot_ack) acks++;
    end
    boot_req = 1'b0;
    tick();
  endtask

  initial begin
    logic [20:0] a1, a2, aw;
    logic [7:0]  dw;
    int wl, ak, tot_w, tot_a, wlow;

    reset = 1'b1; cpu_addr = '0; cpu_din = '0; iorq_n = 1'b1; wr_n = 1'b1;
    cpu_n = 1'b0; romen_n = 1'b1; ramrd_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1;
    mwe_n = 1'b1; en244_n = 1'b1; vram_addr = '0; sram_dq_in = '0;
    boot_addr = '0; boot_data = '0; boot_req = 1'b0; boot_done = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_we_n", 32'(sram_we_n), 32'h1);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
    check("rst_ack", 32'(boot_ack), 32'h0);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_rominit", 32'(rom_initialised), 32'h0);
    check("rst_oe_idle", 32'(memory_oe_n), 32'h1);
    ramrd_n = 1'b0; #1;
    check("rst_latch_ff", 32'(data_to_cpu), 32'hFF);
    check("rst_oe_rd", 32'(memory_oe_n), 32'h0);
    check("rst_ga_ff", 32'(data_to_ga), 32'hFF);
    ramrd_n = 1'b1;
    reset = 1'b0;
    tick();

    // CPU strobes in BOOT must not write
    ras_n = 1'b0; cas_n = 1'b0; mwe_n = 1'b0; cpu_din = 8'hAA;
    wlow = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (!sram_we_n) wlow++; end
    check("boot_cpu_nowrite", 32'(wlow), 32'h0);
    ras_n = 1'b1; cas_n = 1'b1; mwe_n = 1'b1;
    tick();

    // Three lower-ROM boot bytes
    tot_w = 0; tot_a = 0;
    for (int i = 0; i < 3; i++) begin
      boot_byte(21'h100000 + 21'(i), 8'h10 + 8'(i), wl, ak, aw, dw);
      tot_w += wl; tot_a += ak;
    end
    check("boot_we_pulses", 32'(tot_w), 32'h3);
    check("boot_ack_pulses", 32'(tot_a), 32'h3);
    check("boot_last_addr", 32'(aw), 32'h100002);
    check("boot_last_data", 32'(dw), 32'h12);

    // Slot 7 image byte
    boot_byte(21'h120000, 8'h77, wl, ak, aw, dw);
    check("boot_slot7_we", 32'(wl), 32'h1);
    check("boot_slot7_addr", 32'(aw), 32'h120000);

    boot_done = 1'b1;
    tick();
    boot_done = 1'b0;
    check("boot_done_init", 32'(rom_initialised), 32'h1);

    boot_byte(21'h100010, 8'h55, wl, ak, aw, dw);
    check("boot_after_init_we", 32'(wl), 32'h0);
    check("boot_after_init_ack", 32'(ak), 32'h0);

    // Mode 4 block 0, then read data path
    io_write(16'h7F00, 8'hC4);
    access(16'h4000, 1'b0, 1'b1, 8'h5A, a1, a2, wlow);
    check("c4_4000", 32'(a1), 32'h10000);
    check("c4_read_nowrite", 32'(wlow), 32'h0);
    ramrd_n = 1'b0; #1;
    check("rd_data_cpu", 32'(data_to_cpu), 32'h5A);
    check("rd_oe_n", 32'(memory_oe_n), 32'h0);
    ramrd_n = 1'b1;
    check("ga_latch", 32'(data_to_ga), 32'h5A);
    en244_n = 1'b0; #1;
    check("ga_cpu_din", 32'(data_to_ga), 32'hC4);
    en244_n = 1'b1;

    io_write(16'h7F00, 8'hC7);
    access(16'h4000, 1'b0, 1'b1, 8'h00, a1, a2, wlow);
    check("c7_4000", 32'(a1), 32'h1C000);

    io_write(16'h7F00, 8'hF5);
    access(16'h4000, 1'b0, 1'b1, 8'h00, a1, a2, wlow);
    check("f5_4000_8banks", 32'(a1), 32'h74000);
    check("f5_4000_2banks", 32'(a2), 32'h14000);

    io_write(16'h7F00, 8'hC2);
    access(16'h8000, 1'b0, 1'b1, 8'h00, a1, a2, wlow);
    check("c2_8000", 32'(a1), 32'h18000);

    io_write(16'h7F00, 8'hC3);
    access(16'h4000, 1'b0, 1'b1, 8'h00, a1, a2, wlow);
    check("c3_4000", 32'(a1), 32'h0C000);
    access(16'hC000, 1'b0, 1'b1, 8'h00, a1, a2, wlow);
    check("c3_c000", 32'(a1), 32'h1C000);

    // Held IO write: only the first edge decodes
    cpu_addr = 16'h7F00; cpu_din = 8'hC1; iorq_n = 1'b0; wr_n = 1'b0;
    tick(); tick();
    cpu_din = 8'hC2;
    tick(); tick();
    iorq_n = 1'b1; wr_n = 1'b1;
    tick();
    access(16'h8000, 1'b0, 1'b1, 8'h00, a1, a2, wlow);
    check("held_io_c1_only", 32'(a1), 32'h08000);

    // Write cycle strobes
    cpu_addr = 16'h4000; cpu_din = 8'h3C; ras_n = 1'b0;
    tick();
    check("wr_row_addr", 32'(sram_addr), 32'h04000);
    cas_n = 1'b0; mwe_n = 1'b0;
    tick();
    check("wr_we_low", 32'(sram_we_n), 32'h0);
    check("wr_dq_oe", 32'(sram_dq_oe), 32'h1);
    check("wr_dq_out", 32'(sram_dq_out), 32'h3C);
    ras_n = 1'b1; cas_n = 1'b1; mwe_n = 1'b1;
    tick();
    check("wr_end_we", 32'(sram_we_n), 32'h1);
    check("wr_end_oe", 32'(sram_dq_oe), 32'h0);

    // Upper/lower ROM selection
    io_write(16'hDF00, 8'h07);
    access(16'hC000, 1'b1, 1'b0, 8'h00, a1, a2, wlow);
    check("rom7_booted", 32'(a1), 32'h120000);
    check("rom_no_write", 32'(wlow), 32'h0);
    access(16'h0000, 1'b0, 1'b0, 8'h00, a1, a2, wlow);
    check("lower_rom", 32'(a1), 32'h100000);
    io_write(16'hDF00, 8'h05);
    access(16'hC000, 1'b0, 1'b0, 8'h00, a1, a2, wlow);
    check("rom5_unbooted", 32'(a1), 32'h104000);
    io_write(16'hDF00, 8'h14);
    access(16'hC000, 1'b0, 1'b0, 8'h00, a1, a2, wlow);
    check("rom_out_of_range", 32'(a1), 32'h104000);

    // Video access
    vram_addr = 16'h1234; cpu_n = 1'b1; ras_n = 1'b0;
    tick();
    check("vram_addr", 32'(sram_addr), 32'h01234);
    ras_n = 1'b1; cpu_n = 1'b0;
    tick();

    // Reset in the middle of a write
    io_write(16'h7F00, 8'hC4);
    access(16'h4000, 1'b0, 1'b1, 8'h5A, a1, a2, wlow);
    cpu_din = 8'h66; ras_n = 1'b0;
    tick();
    cas_n = 1'b0; mwe_n = 1'b0;
    tick();
    check("pre_abort_we", 32'(sram_we_n), 32'h0);
    reset = 1'b1;
    tick();
    check("abort_we_n", 32'(sram_we_n), 32'h1);
    check("abort_dq_oe", 32'(sram_dq_oe), 32'h0);
    ramrd_n = 1'b0; #1;
    check("abort_latch_ff", 32'(data_to_cpu), 32'hFF);
    check("abort_oe_n", 32'(memory_oe_n), 32'h0);
    ramrd_n = 1'b1;
    reset = 1'b0; ras_n = 1'b1; cas_n = 1'b1; mwe_n = 1'b1;
    tick();
    check("abort_rominit", 32'(rom_initialised), 32'h0);
    boot_done = 1'b1;
    tick();
    boot_done = 1'b0;
    access(16'h4000, 1'b0, 1'b1, 8'h00, a1, a2, wlow);
    check("abort_cfg_cleared", 32'(a1), 32'h04000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpc_memory_mapper.md
CPC_MEMORY_MAPPER -- requirements
Module: cpc_memory_mapper

Interface
REQ-001 The block SHALL have parameter EXP_BANKS, default 8; number of 64KB expansion blocks (power of two, 1..8).
REQ-002 The block SHALL have parameter ROM_SLOTS, default 16; number of upper-ROM slots held in SRAM (power of two, 1..16).
REQ-003 The block SHALL have parameter ROM_BASE, default 21'h100000; SRAM byte base of the ROM area (lower ROM at ROM_BASE, slot n at ROM_BASE+16KB*(n+1)).
REQ-004 The block SHALL have parameter BOOT_ON_RESET, default 1; 1 means reset enters BOOT, 0 means reset enters IDLE.
REQ-005 The block SHALL have ports clk in 1 (system clock, all logic on rising edge) and reset in 1 (synchronous, active-high).
REQ-006 The block SHALL have CPU/GA input ports: cpu_addr in 16; cpu_din in 8; iorq_n, wr_n, cpu_n, romen_n, ramrd_n, ras_n, cas_n, mwe_n, en244_n in 1 each; vram_addr in 16.
REQ-007 The block SHALL have outputs data_to_cpu out 8, memory_oe_n out 1 and data_to_ga out 8.
REQ-008 The block SHALL have SRAM ports sram_addr out 21, sram_dq_out out 8, sram_dq_oe out 1, sram_dq_in in 8 and sram_we_n out 1.
REQ-009 The block SHALL have boot ports boot_addr in 21, boot_data in 8, boot_req in 1, boot_ack out 1, boot_done in 1 and rom_initialised out 1.

Function
REQ-010 IO write decode SHALL fire exactly once per cycle, on the first clk where iorq_n=0 and wr_n=0 after either was high.
REQ-011 On a decoded write with cpu_addr[15]=0 and cpu_din[7:6]=11, the block SHALL set ram_cfg[5:0] from cpu_din[5:0]: [5:3] is the expansion block, [2:0] the mode.
REQ-012 On a decoded write with cpu_addr[13]=0, the block SHALL set rom_sel[7:0] from cpu_din; both decodes may fire together.
REQ-013 CPU RAM page mapping SHALL follow the standard 6128 mode table.
- Modes 0..3 use base 64KB; modes 4..7 use 16KB page (mode-4) of the selected expansion block, at 0x4000 only.
- Modes 1/2/3 map to expansion page 3/4-7/3 as standard.
REQ-014 Expansion block index SHALL be taken modulo EXP_BANKS.
REQ-015 The expansion SRAM address SHALL be 64KB*(1+block) + page*16KB + cpu_addr[13:0].
REQ-016 With romen_n=0 and cpu_addr[15:14]=00, the block SHALL select the lower ROM.
REQ-017 With romen_n=0 and cpu_addr[15:14]=11, the block SHALL select slot rom_sel when rom_sel<ROM_SLOTS and slot_valid[rom_sel]=1, else slot 0.
REQ-018 With cpu_n=1, the SRAM address SHALL be {5'b0, vram_addr}.
REQ-019 The FSM SHALL have states BOOT, IDLE, ROW, RD, WR.
REQ-020 IDLE SHALL go to ROW on ras_n=0, latching sram_addr from the current mapped address.
REQ-021 ROW SHALL go to RD on cas_n=0 with mwe_n=1, and to WR on cas_n=0 with mwe_n=0.
REQ-022 RD and WR SHALL return to IDLE on ras_n=1.
REQ-023 ROM reads SHALL use the same cycle with the ROM address substituted; mwe_n is ignored for ROM, so there are no ROM writes.
REQ-024 In RD, the block SHALL capture sram_dq_in into rd_latch each clk.
REQ-025 In WR, the block SHALL drive sram_we_n=0 and sram_dq_oe=1 with sram_dq_out=cpu_din; at all other times sram_we_n=1.
REQ-026 When ramrd_n=0 or romen_n=0, the block SHALL drive data_to_cpu=rd_latch and memory_oe_n=0; otherwise data_to_cpu=FF and memory_oe_n=1.
REQ-027 data_to_ga SHALL be rd_latch when en244_n=1, else cpu_din.
REQ-028 In BOOT, the block SHALL ignore CPU/GA strobes. On a boot_req rising edge it SHALL drive sram_addr=boot_addr, sram_dq_out=boot_data, sram_dq_oe=1 and sram_we_n=0 for one clk, then pulse boot_ack for one clk.
REQ-029 Any boot write into slot n's window SHALL set slot_valid[n].
REQ-030 boot_done=1 in BOOT SHALL move to IDLE and set rom_initialised=1; a pending boot_req is completed first.
REQ-031 A boot_req while rom_initialised=1 SHALL be ignored, with no ack.

Reset
REQ-032 Reset SHALL set ram_cfg=0, rom_sel=0, slot_valid=0 (bit 0 set if BOOT_ON_RESET=0), rd_latch=FF, sram_we_n=1, sram_dq_oe=0, boot_ack=0 and sram_addr=0.
REQ-033 Reset SHALL clear rom_initialised only when BOOT_ON_RESET=1, and set the state to BOOT or IDLE per BOOT_ON_RESET.
REQ-034 Reset mid-access SHALL abort; the next cycle has sram_we_n=1 and no partial write.

Verification
REQ-035 IO write addr 7F00 data C4, then CPU read 4000 -> sram_addr=0x10000 (block 0, page 0); data C7 -> 0x1C000.
REQ-036 EXP_BANKS=2, write data F5 (block 6, mode 5) -> block 0, CPU addr 4000 -> sram_addr=0x14000.
REQ-037 rom_sel=7 with slot 7 booted, read C000 romen_n=0 -> sram_addr=ROM_BASE+0x20000; rom_sel=7 unbooted -> ROM_BASE+0x4000.
REQ-038 Boot 3 bytes at 0x100000..2 -> three sram_we_n pulses, three boot_ack pulses; boot_done -> rom_initialised=1; CPU strobes during BOOT produce no SRAM writes.
REQ-039 Hold iorq_n=0 and wr_n=0 for 4 clk with data C1 then C2 -> ram_cfg takes C1 only.
REQ-040 Assert reset during WR -> next clk has sram_we_n=1, ram_cfg=0, and rd_latch=FF so data_to_cpu=FF whenever memory_oe_n=0.
